// File: rtl/subcarrier_mapper.sv
// Subcarrier mapper: BPSK/QPSK/16-QAM/64-QAM, pilot and null slots
// mapped to Q2.13 I/Q samples, buffered in a 4-deep output FIFO.
module subcarrier_mapper (
   input  logic               clk,
   input  logic               reset,
   input  logic               en_mapping,
   input  logic               is_zero,
   input  logic               is_pilot,
   input  logic               pilot_indicator,
   input  logic [2:0]         bpsc,
   input  logic [5:0]         intlv_bits,
   output logic               ostream_val,
   output logic signed [15:0] ostream_i,
   output logic signed [15:0] ostream_q,
   output logic               ostream_last,
   input  logic               ostream_rdy,
   output logic               stall,
   output logic               overflow,
   output logic               bpsc_err
);

   localparam logic signed [15:0] ONE   = 16'sd8192;
   localparam logic signed [15:0] QPSK  = 16'sd5793;
   localparam logic [2:0]         DEPTH = 3'd4;

   logic signed [15:0] map_i;
   logic signed [15:0] map_q;
   logic               map_bad;

   logic signed [15:0] mem_i [4];
   logic signed [15:0] mem_q [4];
   logic               mem_last [4];

   logic [1:0] wr_ptr;
   logic [1:0] rd_ptr;
   logic [2:0] count;
   logic [5:0] slot_cnt;

   logic empty;
   logic full;
   logic pop;
   logic push;

   // 16-QAM level, argument is {b0, b1} (Gray coded)
   function automatic logic signed [15:0] lvl16(input logic [1:0] s);
      logic signed [15:0] r;
      case (s)
         2'b00:   r = -16'sd7772;
         2'b01:   r = -16'sd2591;
         2'b11:   r = 16'sd2591;
         default: r = 16'sd7772;
      endcase
      return r;
   endfunction

   // 64-QAM level, argument is {b0, b1, b2} (Gray coded)
   function automatic logic signed [15:0] lvl64(input logic [2:0] s);
      logic signed [15:0] r;
      case (s)
         3'b000:  r = -16'sd8848;
         3'b001:  r = -16'sd6320;
         3'b011:  r = -16'sd3792;
         3'b010:  r = -16'sd1264;
         3'b110:  r = 16'sd1264;
         3'b111:  r = 16'sd3792;
         3'b101:  r = 16'sd6320;
         default: r = 16'sd8848;
      endcase
      return r;
   endfunction

   always_comb begin
      map_i   = '0;
      map_q   = '0;
      map_bad = 1'b0;
      if (is_zero) begin
         map_i = '0;
      end else if (is_pilot) begin
         map_i = pilot_indicator ? ONE : -ONE;
      end else begin
         case (bpsc)
            3'd1: begin
               map_i = intlv_bits[0] ? ONE : -ONE;
            end
            3'd2: begin
               map_i = intlv_bits[0] ? QPSK : -QPSK;
               map_q = intlv_bits[1] ? QPSK : -QPSK;
            end
            3'd4: begin
               map_i = lvl16({intlv_bits[0], intlv_bits[1]});
               map_q = lvl16({intlv_bits[2], intlv_bits[3]});
            end
            3'd6: begin
               map_i = lvl64({intlv_bits[0], intlv_bits[1], intlv_bits[2]});
               map_q = lvl64({intlv_bits[3], intlv_bits[4], intlv_bits[5]});
            end
            default: map_bad = 1'b1;
         endcase
      end
   end

   assign empty = (count == 3'd0);
   assign full  = (count == DEPTH);
   assign pop   = !empty && ostream_rdy;
   // a full FIFO still takes a write when the head leaves the same cycle
   assign push  = en_mapping && (!full || pop);

   always_ff @(posedge clk) begin
      if (push) begin
         mem_i[wr_ptr]    <= map_i;
         mem_q[wr_ptr]    <= map_q;
         mem_last[wr_ptr] <= (slot_cnt == 6'd63);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         slot_cnt <= '0;
         overflow <= 1'b0;
         bpsc_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr   <= wr_ptr + 2'd1;
            slot_cnt <= slot_cnt + 6'd1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 2'd1;
         end
         unique case (1'b1)
            push && !pop: count <= count + 3'd1;
            pop && !push: count <= count - 3'd1;
            default:      count <= count;
         endcase
         if (en_mapping && full && !pop) begin
            overflow <= 1'b1;
         end
         if (en_mapping && map_bad) begin
            bpsc_err <= 1'b1;
         end
      end
   end

   assign ostream_val  = !empty;
   assign ostream_i    = empty ? 16'sd0 : mem_i[rd_ptr];
   assign ostream_q    = empty ? 16'sd0 : mem_q[rd_ptr];
   assign ostream_last = empty ? 1'b0 : mem_last[rd_ptr];
   assign stall        = (count >= 3'd3);

endmodule

// File: tb/tb_subcarrier_mapper.sv
// Directed self-checking bench for subcarrier_mapper.
// Hand-computed expected I/Q values, immediate assertions per check.
module tb_subcarrier_mapper;

   logic               clk = 1'b0;
   logic               reset;
   logic               en_mapping;
   logic               is_zero;
   logic               is_pilot;
   logic               pilot_indicator;
   logic [2:0]         bpsc;
   logic [5:0]         intlv_bits;
   logic               ostream_val;
   logic signed [15:0] ostream_i;
   logic signed [15:0] ostream_q;
   logic               ostream_last;
   logic               ostream_rdy;
   logic               stall;
   logic               overflow;
   logic               bpsc_err;

   int n_chk  = 0;
   int n_fail = 0;

   subcarrier_mapper dut (
      .clk             (clk),
      .reset           (reset),
      .en_mapping      (en_mapping),
      .is_zero         (is_zero),
      .is_pilot        (is_pilot),
      .pilot_indicator (pilot_indicator),
      .bpsc            (bpsc),
      .intlv_bits      (intlv_bits),
      .ostream_val     (ostream_val),
      .ostream_i       (ostream_i),
      .ostream_q       (ostream_q),
      .ostream_last    (ostream_last),
      .ostream_rdy     (ostream_rdy),
      .stall           (stall),
      .overflow        (overflow),
      .bpsc_err        (bpsc_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic signed [31:0] obs,
                      input logic signed [31:0] exp);
      n_chk++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic en, input logic z, input logic p,
                        input logic pi, input logic [2:0] b,
                        input logic [5:0] bits);
      en_mapping      = en;
      is_zero         = z;
      is_pilot        = p;
      pilot_indicator = pi;
      bpsc            = b;
      intlv_bits      = bits;
   endtask

   task automatic chk_iq(input string tag, input int ei, input int eq);
      chk({tag, "_val"}, ostream_val, 1);
      chk({tag, "_i"}, ostream_i, ei);
      chk({tag, "_q"}, ostream_q, eq);
   endtask

   int         q16 [4] = '{-7772, 7772, -2591, 2591};
   int         q64 [8] = '{-8848, 8848, -1264, 1264, -6320, 6320, -3792, 3792};
   int         bpsk_bits [3] = '{1, 0, 1};
   int         n_last;
   logic [1:0] u2;
   logic [1:0] uq2;
   logic [2:0] v3;
   logic [2:0] vq3;

   initial begin
      reset       = 1'b1;
      ostream_rdy = 1'b1;
      drive(0, 0, 0, 0, 3'd0, 6'd0);
      #3;
      chk("rst_val", ostream_val, 0);
      chk("rst_i", ostream_i, 0);
      chk("rst_q", ostream_q, 0);
      chk("rst_last", ostream_last, 0);
      chk("rst_stall", stall, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_berr", bpsc_err, 0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // BPSK 1,0,1
      for (int k = 0; k < 3; k++) begin
         drive(1, 0, 0, 0, 3'd1, 6'(bpsk_bits[k]));
         tick();
         chk_iq("bpsk", bpsk_bits[k] == 1 ? 8192 : -8192, 0);
      end
      drive(0, 0, 0, 0, 3'd1, 6'd0);
      tick();
      chk("bpsk_idle_val", ostream_val, 0);

      // null beats pilot; pilots ignore a bad bpsc
      drive(1, 1, 1, 1, 3'd0, 6'b111111);
      tick();
      chk_iq("null", 0, 0);
      drive(1, 0, 1, 0, 3'd3, 6'b111111);
      tick();
      chk_iq("pilot_neg", -8192, 0);
      drive(1, 0, 1, 1, 3'd7, 6'd0);
      tick();
      chk_iq("pilot_pos", 8192, 0);
      chk("pilot_no_berr", bpsc_err, 0);

      // QPSK
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 3'd2, 6'(k));
         tick();
         chk_iq("qpsk", k[0] ? 5793 : -5793, k[1] ? 5793 : -5793);
      end

      // 16-QAM
      for (int k = 0; k < 4; k++) begin
         u2  = 2'(k);
         uq2 = 2'(3 - k);
         drive(1, 0, 0, 0, 3'd4, {2'b00, uq2, u2});
         tick();
         chk_iq("qam16", q16[u2], q16[uq2]);
      end

      // 64-QAM
      for (int k = 0; k < 8; k++) begin
         v3  = 3'(k);
         vq3 = 3'(7 - k);
         drive(1, 0, 0, 0, 3'd6, {vq3, v3});
         tick();
         chk_iq("qam64", q64[v3], q64[vq3]);
      end
      // b0=1 b1=1 b2=0 b3=1 b4=0 b5=1
      drive(1, 0, 0, 0, 3'd6, 6'b101_011);
      tick();
      chk_iq("qam64_vec", 1264, 6320);

      // unsupported bpsc on a data slot
      drive(1, 0, 0, 0, 3'd3, 6'b111111);
      tick();
      chk_iq("bad_bpsc", 0, 0);
      chk("bad_bpsc_err", bpsc_err, 1);
      drive(0, 0, 0, 0, 3'd1, 6'd0);
      tick();
      chk("idle_val", ostream_val, 0);
      chk("berr_sticky", bpsc_err, 1);
      chk("pre_ovf", overflow, 0);

      // backpressure: 5 writes with rdy low
      ostream_rdy = 1'b0;
      for (int k = 0; k < 4; k++) begin
         drive(1, 0, 0, 0, 3'd2, 6'(k));
         tick();
         chk("bp_stall", stall, k >= 2 ? 1 : 0);
         chk("bp_ovf", overflow, 0);
         chk_iq("bp_head", -5793, -5793);
      end
      drive(1, 0, 1, 1, 3'd0, 6'd0);
      tick();
      chk("bp_ovf5", overflow, 1);
      chk_iq("bp_hold", -5793, -5793);

      // full FIFO: write plus pop in the same cycle
      ostream_rdy = 1'b1;
      drive(1, 0, 0, 0, 3'd1, 6'd1);
      #1;
      chk_iq("wp_head", -5793, -5793);
      tick();
      chk_iq("wp_next", 5793, -5793);
      chk("wp_stall", stall, 1);
      drive(0, 0, 0, 0, 3'd1, 6'd0);
      tick();
      chk_iq("drain3", -5793, 5793);
      tick();
      chk_iq("drain4", 5793, 5793);
      tick();
      chk_iq("drain6", 8192, 0);
      chk("drain_stall", stall, 0);
      tick();
      chk("drain_empty", ostream_val, 0);
      chk("ovf_sticky", overflow, 1);

      // async reset with 2 buffered samples
      ostream_rdy = 1'b0;
      drive(1, 0, 0, 0, 3'd1, 6'd1);
      tick();
      tick();
      drive(0, 0, 0, 0, 3'd1, 6'd0);
      chk("pre_rst_val", ostream_val, 1);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_val", ostream_val, 0);
      chk("arst_i", ostream_i, 0);
      chk("arst_last", ostream_last, 0);
      chk("arst_ovf", overflow, 0);
      chk("arst_berr", bpsc_err, 0);
      #1;
      reset = 1'b0;
      ostream_rdy = 1'b1;
      tick();
      chk("post_rst_val", ostream_val, 0);

      // framing: last on samples 64 and 128
      n_last = 0;
      for (int k = 0; k < 128; k++) begin
         drive(1, 0, 0, 0, 3'd1, 6'(k % 2));
         tick();
         chk("frm_last", ostream_last, (k == 63 || k == 127) ? 1 : 0);
         chk("frm_i", ostream_i, (k % 2) == 1 ? 8192 : -8192);
         if (ostream_last === 1'b1) n_last++;
      end
      chk("frm_nlast", n_last, 2);
      drive(0, 0, 0, 0, 3'd1, 6'd0);
      tick();
      chk("frm_end_val", ostream_val, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
